pipe_stage_reg: RTL and testbench
=================================

# pipe_stage_reg

Parametrised, elastic successor to the fixed IF/ID pipeline register. It carries a multi-field payload (e.g. PC + instruction) between two pipeline stages using a valid/ready handshake. It keeps the familiar flush and freeze controls and adds an optional skid entry, so the upstream ready is registered and the stage sustains one transfer per cycle under back-pressure. The same block is instanced at every stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB), with fields set per instance.

## Interface
- WORD_LEN, 16, width of one payload field
- NUM_FIELDS, 2, number of fields; payload width P = WORD_LEN*NUM_FIELDS
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  asynchronous, active-low reset (asserted when 0)
- flush  input  1  synchronous: discard all held entries
- freeze  input  1  synchronous: hold all state, block both handshakes
- in_valid  input  1  upstream offers in_data
- in_ready  output  1  stage can accept this cycle
- in_data  input  P  payload; field k = bits [k*WORD_LEN +: WORD_LEN]
- out_valid  output  1  out_data is valid
- out_ready  input  1  downstream accepts this cycle
- out_data  output  P  payload of the head entry
- occupancy  output  2  number of valid entries (0..2)

## Operation
- Storage:
  - main entry M (valid mv, data md) drives out_valid/out_data;
  - skid entry S (valid sv, data sd).
- Handshake terms:
  - accept = in_valid & in_ready;
  - release = out_valid & out_ready.
- Combinational masking:
  - in_ready = ~flush & ~freeze & ~sv;
  - out_valid = mv & ~flush & ~freeze.
- States: EMPTY (mv=0, sv=0), ONE (mv=1, sv=0), FULL (mv=1, sv=1). occupancy = 0/1/2.
- Transitions (no flush, no freeze):
  - EMPTY: accept -> ONE, md<=in_data.
  - ONE: accept&release -> ONE, md<=in_data.
  - ONE: accept&~release -> FULL, sd<=in_data.
  - ONE: ~accept&release -> EMPTY.
  - FULL: in_ready=0; release -> ONE, md<=sd, sv<=0; otherwise hold.
- flush:
  - Takes priority over freeze.
  - Next edge clears mv, sv, md and sd to 0.
  - No accept or release occurs in a flush cycle.
- freeze (no flush): all registers hold; no transfers.
- Data ordering is strict FIFO; a payload is never duplicated or dropped except by flush.
- md/sd hold stale contents when invalid; they read 0 only after reset or flush.

## Timing
- Reset (rst=0, asynchronous):
  - mv=sv=0, md=sd=0;
  - out_valid=0, out_data=0, occupancy=0;
  - in_ready=0 while rst=0.
- First edge after rst deasserts: in_ready=1 (combinational, given flush=freeze=0).
- Latency: a payload accepted at edge N is presented on out_valid/out_data after edge N (one cycle).
- Throughput: one transfer per cycle with out_ready held 1.
- out_ready dropping for one cycle with in_valid held: the stage absorbs exactly one extra payload into S, then in_ready=0 from the following cycle.
- in_ready depends only on registered sv plus flush/freeze; there is no combinational path from out_ready to in_ready.
- Reset asserted mid-transfer: entries discarded immediately, independent of clk.
- Simultaneous flush & in_valid & out_ready: nothing transfers; the stage is EMPTY after the edge.

## Configuration
- Macro PIPE_STAGE_SKID_EN.
- Defined:
  - skid entry S present, behaviour as above;
  - occupancy reaches 2.
- Undefined:
  - S is not built; states are EMPTY and ONE only;
  - in_ready = ~flush & ~freeze & (~mv | out_ready), which adds a combinational out_ready->in_ready path;
  - occupancy[1] tied 0.
- Both builds share identical reset, flush, freeze and ordering rules.

## Test plan
- Reset: drive rst=0 mid-stream with occupancy=2 -> out_valid=0, out_data=0, occupancy=0 immediately; in_ready=1 one cycle after release.
- Streaming: WORD_LEN=16, NUM_FIELDS=2; send 0x0001_1000, 0x0002_1002, 0x0003_1004 with out_ready=1 -> each appears one cycle after accept, back-to-back, in order.
- Back-pressure (skid build): hold in_valid, out_ready=0 for 3 cycles -> occupancy 1,2,2 and in_ready=0 after the second accept; on out_ready=1, the two payloads drain in order with no loss.
- Flush vs freeze: at occupancy=2, assert flush=1 and freeze=1 together -> next cycle occupancy=0, out_data=0; a payload offered that cycle is not accepted.
- Freeze: at occupancy=1 with out_ready=1, hold freeze for 4 cycles -> out_valid=0, in_ready=0 and data unchanged; after release the same payload is presented.
- Non-skid build: out_ready=0 with mv=1 -> in_ready=0 the same cycle; toggling out_ready=1 -> in_ready=1 combinationally, and a simultaneous accept and release occur on one edge.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// +----------------------------------------------------------------------------+
// | Module  : pipe_stage_reg                                                   |
// | Brief   : Elastic valid/ready pipeline register with flush/freeze and an   |
// |           optional skid entry (enabled by macro PIPE_STAGE_SKID_EN).       |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

module pipe_stage_reg #(
    parameter int unsigned WORD_LEN   = 16,
    parameter int unsigned NUM_FIELDS = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           flush,
    input  logic                           freeze,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [WORD_LEN*NUM_FIELDS-1:0] in_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [WORD_LEN*NUM_FIELDS-1:0] out_data,
    output logic [1:0]                     occupancy
);

    localparam int unsigned c_PW = WORD_LEN * NUM_FIELDS;

    // Encodings equal the entry count so occupancy can be read straight off the state.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t            r_state;
    logic [c_PW-1:0]   r_md;
    logic              r_live;
    logic              w_mv;
    logic              w_accept;
    logic              w_release;

    assign w_mv      = (r_state != ST_EMPTY);
    assign out_valid = w_mv & ~flush & ~freeze;
    assign out_data  = r_md;
    assign w_accept  = in_valid & in_ready;
    assign w_release = out_valid & out_ready;

`ifdef PIPE_STAGE_SKID_EN
    logic [c_PW-1:0]   r_sd;
    logic              w_sv;

    // Ready comes only from registered state, breaking the out_ready->in_ready path.
    assign w_sv      = (r_state == ST_FULL);
    assign in_ready  = r_live & ~flush & ~freeze & ~w_sv;
    assign occupancy = r_state;
`else
    assign in_ready  = r_live & ~flush & ~freeze & (~w_mv | out_ready);
    assign occupancy = {1'b0, w_mv};
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_EMPTY;
            r_md    <= '0;
            r_live  <= 1'b0;
`ifdef PIPE_STAGE_SKID_EN
            r_sd    <= '0;
`endif
        end else begin
            r_live <= 1'b1;
            if (flush) begin
                r_state <= ST_EMPTY;
                r_md    <= '0;
`ifdef PIPE_STAGE_SKID_EN
                r_sd    <= '0;
`endif
            end else if (!freeze) begin
                case (r_state)
                    ST_EMPTY: begin
                        if (w_accept) begin
                            r_md    <= in_data;
                            r_state <= ST_ONE;
                        end
                    end
                    ST_ONE: begin
                        if (w_accept && w_release) begin
                            r_md <= in_data;
`ifdef PIPE_STAGE_SKID_EN
                        end else if (w_accept) begin
                            r_sd    <= in_data;
                            r_state <= ST_FULL;
`endif
                        end else if (w_release) begin
                            r_state <= ST_EMPTY;
                        end
                    end
`ifdef PIPE_STAGE_SKID_EN
                    ST_FULL: begin
                        if (w_release) begin
                            r_md    <= r_sd;
                            r_state <= ST_ONE;
                        end
                    end
`endif
                    default: r_state <= ST_EMPTY;
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: directed stimulus pushes expected payloads,
// an independent monitor pops and compares on every output transfer.
`default_nettype none

module tb_pipe_stage_reg;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        freeze;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [1:0]  occupancy;

    int          checks;
    int          errors;
    logic [31:0] exp_q[$];

    pipe_stage_reg #(.WORD_LEN(16), .NUM_FIELDS(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .freeze    (freeze),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Output monitor: a transfer completes on the next rising edge whenever valid & ready.
    always @(negedge clk) begin
        if (rst === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: got %h expected none at %0t", out_data, $time);
            end else begin
                chk("sb_data", out_data, exp_q.pop_front());
            end
        end
    end

    initial begin
        rst = 1'b0; flush = 1'b0; freeze = 1'b0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        checks = 0; errors = 0;

        // Reset state
        tick(); tick();
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_occ", {30'd0, occupancy}, 32'd0);
        rst = 1'b1;
        tick();
        chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Streaming with out_ready held high
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data = 32'h0001_1000; exp_q.push_back(32'h0001_1000); tick();
        chk("stream_occ", {30'd0, occupancy}, 32'd1);
        chk("stream_first", out_data, 32'h0001_1000);
        in_data = 32'h0002_1002; exp_q.push_back(32'h0002_1002); tick();
        in_data = 32'h0003_1004; exp_q.push_back(32'h0003_1004); tick();
        in_valid = 1'b0;
        tick();
        chk("stream_drained", {30'd0, occupancy}, 32'd0);

        // Back-pressure
`ifdef PIPE_STAGE_SKID_EN
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data = 32'h0000_00A1; exp_q.push_back(32'h0000_00A1); tick();
        chk("bp_occ1", {30'd0, occupancy}, 32'd1);
        chk("bp_ready1", {31'd0, in_ready}, 32'd1);
        in_data = 32'h0000_00B2; exp_q.push_back(32'h0000_00B2); tick();
        chk("bp_occ2", {30'd0, occupancy}, 32'd2);
        chk("bp_ready2", {31'd0, in_ready}, 32'd0);
        in_data = 32'h0000_00C3; tick();
        chk("bp_occ3", {30'd0, occupancy}, 32'd2);
        out_ready = 1'b1;
        #1;
        chk("bp_ready_reg", {31'd0, in_ready}, 32'd0);
        tick();
        chk("bp_ready_back", {31'd0, in_ready}, 32'd1);
        exp_q.push_back(32'h0000_00C3);
        tick();
        in_valid = 1'b0;
        tick();
        chk("bp_drained", {30'd0, occupancy}, 32'd0);
`else
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data = 32'h0000_00A1; exp_q.push_back(32'h0000_00A1); tick();
        in_valid = 1'b0;
        chk("ns_occ1", {30'd0, occupancy}, 32'd1);
        chk("ns_ready_low", {31'd0, in_ready}, 32'd0);
        out_ready = 1'b1;
        #1;
        chk("ns_ready_comb", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        in_data = 32'h0000_00B2; exp_q.push_back(32'h0000_00B2); tick();
        chk("ns_swap_occ", {30'd0, occupancy}, 32'd1);
        chk("ns_swap_data", out_data, 32'h0000_00B2);
        in_valid = 1'b0;
        tick();
        chk("ns_drained", {30'd0, occupancy}, 32'd0);
`endif

        // Flush takes priority over freeze
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data = 32'h0000_0D01; tick();
`ifdef PIPE_STAGE_SKID_EN
        in_data = 32'h0000_0D02; tick();
        chk("fl_pre_occ", {30'd0, occupancy}, 32'd2);
`else
        chk("fl_pre_occ", {30'd0, occupancy}, 32'd1);
`endif
        flush = 1'b1; freeze = 1'b1; out_ready = 1'b1;
        in_data = 32'h0000_0DFF;
        #1;
        chk("fl_out_valid", {31'd0, out_valid}, 32'd0);
        chk("fl_in_ready", {31'd0, in_ready}, 32'd0);
        tick();
        flush = 1'b0; freeze = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        #1;
        chk("fl_occ", {30'd0, occupancy}, 32'd0);
        chk("fl_data", out_data, 32'd0);
        chk("fl_valid_after", {31'd0, out_valid}, 32'd0);

        // Freeze holds everything
        in_valid = 1'b1;
        in_data = 32'h0000_0E01; exp_q.push_back(32'h0000_0E01); tick();
        freeze = 1'b1; out_ready = 1'b1; in_data = 32'h0000_0EFF;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("fz_out_valid", {31'd0, out_valid}, 32'd0);
            chk("fz_in_ready", {31'd0, in_ready}, 32'd0);
            chk("fz_data", out_data, 32'h0000_0E01);
            chk("fz_occ", {30'd0, occupancy}, 32'd1);
            tick();
        end
        freeze = 1'b0; in_valid = 1'b0;
        #1;
        chk("fz_resume_valid", {31'd0, out_valid}, 32'd1);
        tick();
        chk("fz_drained", {30'd0, occupancy}, 32'd0);

        // Asynchronous reset mid-stream
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data = 32'h0000_0F01; tick();
`ifdef PIPE_STAGE_SKID_EN
        in_data = 32'h0000_0F02; tick();
`endif
        in_valid = 1'b0;
        #2;
        rst = 1'b0;
        exp_q.delete();
        #1;
        chk("ar_out_valid", {31'd0, out_valid}, 32'd0);
        chk("ar_out_data", out_data, 32'd0);
        chk("ar_occ", {30'd0, occupancy}, 32'd0);
        chk("ar_in_ready", {31'd0, in_ready}, 32'd0);
        tick();
        rst = 1'b1;
        tick();
        chk("ar_ready_back", {31'd0, in_ready}, 32'd1);

        tick();
        chk("sb_leftover", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
